// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg
// Shared constants and helpers for the Wishbone GPIO slave.
//   WB_AW / WB_DW / WB_SELW : bus address, data and byte-select widths
//   ADDR_*                  : register word addresses (addr[2:0])
//   lane_mask / byte_merge  : byte-lane expansion and merge for partial writes
package wb_gpio_pkg;

  localparam int WB_AW   = 30;
  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  localparam logic [2:0] ADDR_LED     = 3'd0;
  localparam logic [2:0] ADDR_SW      = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_IE      = 3'd3;
  localparam logic [2:0] ADDR_LED_TGL = 3'd4;

  function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SELW-1:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0]   old_val,
                                                  input logic [WB_DW-1:0]   new_val,
                                                  input logic [WB_SELW-1:0] sel);
    byte_merge = (old_val & ~lane_mask(sel)) | (new_val & lane_mask(sel));
  endfunction

endpackage

// File: rtl/wb_gpio_ctrl_if.sv
// wb_gpio_ctrl_if
// Pipelined Wishbone B4 slave-side bundle for the GPIO peripheral.
//   cyc, stb, we, addr, dat_w, sel : master -> slave request
//   ack, stall, dat_r              : slave -> master response
interface wb_gpio_ctrl_if;
  import wb_gpio_pkg::*;

  logic               cyc;
  logic               stb;
  logic               we;
  logic [WB_AW-1:0]   addr;
  logic [WB_DW-1:0]   dat_w;
  logic [WB_SELW-1:0] sel;
  logic               ack;
  logic               stall;
  logic [WB_DW-1:0]   dat_r;

  modport master (output cyc, stb, we, addr, dat_w, sel,
                  input  ack, stall, dat_r);

  modport slave  (input  cyc, stb, we, addr, dat_w, sel,
                  output ack, stall, dat_r);

endinterface

// File: rtl/wb_sw_debounce.sv
// wb_sw_debounce
// Two-flop synchroniser, free-running sample prescaler and per-bit debouncer
// for asynchronous switch inputs.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_sw           : raw asynchronous switch inputs
//   o_sw           : debounced switch state
//   o_change       : one-cycle pulse per bit, coincident with o_sw updating
module wb_sw_debounce #(
  parameter int NSW             = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NSW-1:0] i_sw,
  output logic [NSW-1:0] o_sw,
  output logic [NSW-1:0] o_change
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NSW-1:0] sync1;
  logic [NSW-1:0] sync2;
  logic [NSW-1:0] prev;
  logic [CW-1:0]  cnt;
  logic           tick;

  assign tick = (cnt == CNT_LAST);

  // A bit is accepted only when two consecutive samples agree and differ
  // from the current debounced value.
  assign o_change = tick ? (~(sync2 ^ prev) & (sync2 ^ o_sw)) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      cnt   <= '0;
      o_sw  <= '0;
    end else begin
      sync1 <= i_sw;
      sync2 <= sync1;
      cnt   <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        prev <= sync2;
        o_sw <= o_sw ^ o_change;
      end
    end
  end

endmodule

// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl
// Wishbone B4 pipelined GPIO slave: LED drive, debounced switches with edge
// latching and a level interrupt.
//   i_clk, i_reset : clock, synchronous active-high reset
//   wb             : Wishbone slave bundle (cyc/stb/we/addr/dat_w/sel in,
//                    ack/stall/dat_r out)
//   i_switches     : asynchronous switch inputs
//   o_leds         : LED drive
//   o_int          : level interrupt, high while any enabled edge bit is set
module wb_gpio_ctrl
  import wb_gpio_pkg::*;
#(
  parameter int NLED            = 16,
  parameter int NSW             = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  wb_gpio_ctrl_if.slave   wb,
  input  logic [NSW-1:0]  i_switches,
  output logic [NLED-1:0] o_leds,
  output logic            o_int
);

  logic             accept;
  logic             wr;
  logic [2:0]       reg_addr;
  logic [WB_DW-1:0] wr_lanes;
  logic [WB_DW-1:0] rd_val;
  logic             ack_q;
  logic [WB_DW-1:0] dat_q;
  logic [NLED-1:0]  led_q;
  logic [NSW-1:0]   edge_q;
  logic [NSW-1:0]   ie_q;
  logic [NSW-1:0]   w1c;
  logic             int_q;
  logic [NSW-1:0]   sw_deb;
  logic [NSW-1:0]   sw_chg;
  logic             unused_addr_hi;

  wb_sw_debounce #(
    .NSW             (NSW),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_sw     (i_switches),
    .o_sw     (sw_deb),
    .o_change (sw_chg)
  );

  assign wb.stall       = i_reset;
  assign accept         = wb.cyc & wb.stb & ~wb.stall;
  assign wr             = accept & wb.we;
  assign reg_addr       = wb.addr[2:0];
  assign wr_lanes       = wb.dat_w & lane_mask(wb.sel);
  assign unused_addr_hi = ^wb.addr[WB_AW-1:3];

  // The ack is held back whenever the master has dropped the cycle or a
  // reset is in progress, so an abandoned transaction never completes.
  assign wb.ack   = ack_q & wb.cyc & ~i_reset;
  assign wb.dat_r = dat_q;
  assign o_leds   = led_q;
  assign o_int    = int_q;

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      ADDR_LED:  rd_val = WB_DW'(led_q);
      ADDR_SW:   rd_val = WB_DW'(sw_deb);
      ADDR_EDGE: rd_val = WB_DW'(edge_q);
      ADDR_IE:   rd_val = WB_DW'(ie_q);
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    w1c = '0;
    if (wr && reg_addr == ADDR_EDGE) begin
      w1c = NSW'(wr_lanes);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      led_q  <= '0;
      edge_q <= '0;
      ie_q   <= '0;
      int_q  <= 1'b0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept && !wb.we) ? rd_val : '0;

      if (wr && reg_addr == ADDR_LED) begin
        led_q <= NLED'(byte_merge(WB_DW'(led_q), wb.dat_w, wb.sel));
      end else if (wr && reg_addr == ADDR_LED_TGL) begin
        led_q <= led_q ^ NLED'(wr_lanes);
      end

      if (wr && reg_addr == ADDR_IE) begin
        ie_q <= NSW'(byte_merge(WB_DW'(ie_q), wb.dat_w, wb.sel));
      end

      // A new edge in the same cycle as a clear keeps the bit set.
      edge_q <= (edge_q & ~w1c) | sw_chg;
      int_q  <= |(edge_q & ie_q);
    end
  end

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
module tb_wb_gpio_ctrl;
  import wb_gpio_pkg::*;

  localparam int NLED = 16;
  localparam int NSW  = 16;
  localparam int DB   = 4;

  logic            i_clk   = 1'b0;
  logic            i_reset = 1'b1;
  logic [NSW-1:0]  sw      = '0;
  logic [NLED-1:0] leds;
  logic            irq;

  wb_gpio_ctrl_if bus();

  wb_gpio_ctrl #(
    .NLED            (NLED),
    .NSW             (NSW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .wb         (bus),
    .i_switches (sw),
    .o_leds     (leds),
    .o_int      (irq)
  );

  always #5 i_clk = ~i_clk;

  // Clock edges since the last reset edge; the prescaler restarts at reset,
  // so sample ticks fall on every DB-th edge of this count.
  int unsigned ecount = 0;
  always @(posedge i_clk) ecount <= i_reset ? 0 : ecount + 1;

  int total  = 0;
  int passed = 0;

  logic [31:0] led_m, ie_m, sw_m, edge_m, rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = we;
    bus.addr  = {27'd0, a};
    bus.dat_w = d;
    bus.sel   = s;
  endtask

  task automatic access(input logic we, input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rdata);
    drive(we, a, d, s);
    @(posedge i_clk);
    #1;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
    check("ack", 32'(bus.ack), 32'd1);
    rdata   = bus.dat_r;
    bus.cyc = 1'b0;
  endtask

  // Reference for byte-lane register updates: replace or xor each selected
  // byte, then drop bits beyond the implemented width.
  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s, input bit tgl, input int width);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = tgl ? (old[8*b +: 8] ^ d[8*b +: 8]) : d[8*b +: 8];
    end
    for (int i = width; i < 32; i++) r[i] = 1'b0;
    return r;
  endfunction

  task automatic align_tick();
    for (int i = 0; i < 2 * DB; i++) begin
      @(posedge i_clk);
      #1;
      if (ecount != 0 && (ecount % DB) == 0) break;
    end
  endtask

  logic        b_we   [4];
  logic [2:0]  b_addr [4];
  logic [31:0] b_data [4];
  logic [31:0] b_exp  [4];

  initial begin
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.addr = '0; bus.dat_w = '0; bus.sel = '0;
    i_reset = 1'b1;
    idle(3);
    check("rst_leds",  32'(leds),      32'd0);
    check("rst_int",   32'(irq),       32'd0);
    check("rst_ack",   32'(bus.ack),   32'd0);
    check("rst_data",  bus.dat_r,      32'd0);
    check("rst_stall", 32'(bus.stall), 32'd1);
    i_reset = 1'b0;
    #1;
    check("stall_low", 32'(bus.stall), 32'd0);
    led_m = 0; ie_m = 0; sw_m = 0; edge_m = 0;

    access(1, ADDR_LED, 32'h0000A5A5, 4'b0001, rd);
    check("led_b0", 32'(leds), 32'h00A5);
    check("wr_data0", rd, 32'd0);
    access(1, ADDR_LED, 32'h00001234, 4'b0011, rd);
    check("led_b01", 32'(leds), 32'h1234);
    access(1, ADDR_LED_TGL, 32'h000000FF, 4'b1111, rd);
    check("led_tgl", 32'(leds), 32'h12CB);
    access(0, ADDR_LED_TGL, 32'h0, 4'b1111, rd);
    check("tgl_rd0", rd, 32'd0);
    led_m = 32'h12CB;

    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      logic [3:0]  s;
      int          op;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      op = $urandom_range(0, 5);
      case (op)
        0: begin
          led_m = lanes(led_m, d, s, 0, NLED);
          access(1, ADDR_LED, d, s, rd);
        end
        1: begin
          led_m = lanes(led_m, d, s, 1, NLED);
          access(1, ADDR_LED_TGL, d, s, rd);
        end
        2: begin
          ie_m = lanes(ie_m, d, s, 0, NSW);
          access(1, ADDR_IE, d, s, rd);
        end
        3: begin
          access(0, ADDR_LED, d, s, rd);
          check("rnd_rd_led", rd, led_m);
        end
        4: begin
          access(0, ADDR_IE, d, s, rd);
          check("rnd_rd_ie", rd, ie_m);
        end
        default: begin
          access(1, 3'($urandom_range(5, 7)), d, s, rd);
          access(0, 3'($urandom_range(5, 7)), d, s, rd);
          check("rnd_rd_hi", rd, 32'd0);
          access(1, ADDR_SW, d, s, rd);
          access(0, ADDR_SW, d, s, rd);
          check("rnd_sw_ro", rd, sw_m);
        end
      endcase
      check("rnd_leds", 32'(leds), led_m);
    end
    access(1, ADDR_IE, 32'h0, 4'b1111, rd);
    ie_m = 0;

    // Stable switch change: 2FF + up to three sample periods.
    sw[3] = 1'b1;
    idle(14);
    sw_m = 32'h8; edge_m = 32'h8;
    access(0, ADDR_SW, 32'h0, 4'hF, rd);
    check("sw_stable", rd, sw_m);
    access(0, ADDR_EDGE, 32'h0, 4'hF, rd);
    check("edge_set", rd, edge_m);
    check("int_masked", 32'(irq), 32'd0);

    // Glitch shorter than one sample period must be rejected.
    sw[5] = 1'b1;
    idle(2);
    sw[5] = 1'b0;
    idle(20);
    access(0, ADDR_SW, 32'h0, 4'hF, rd);
    check("glitch_sw", rd, sw_m);
    access(0, ADDR_EDGE, 32'h0, 4'hF, rd);
    check("glitch_edge", rd, edge_m);

    access(1, ADDR_IE, 32'h0008, 4'b0011, rd);
    idle(1);
    check("int_on", 32'(irq), 32'd1);

    access(1, ADDR_EDGE, 32'h0008, 4'b0001, rd);
    check("int_lag", 32'(irq), 32'd1);
    access(0, ADDR_EDGE, 32'h0, 4'hF, rd);
    check("edge_w1c", rd, 32'd0);
    check("int_off", 32'(irq), 32'd0);

    // Release switch 3 right after a tick; the debounced change lands
    // exactly two ticks later, which is when the W1C is accepted.
    align_tick();
    sw[3] = 1'b0;
    idle(2 * DB - 1);
    access(1, ADDR_EDGE, 32'h0008, 4'b0001, rd);
    sw_m = 32'h0;
    access(0, ADDR_EDGE, 32'h0, 4'hF, rd);
    check("edge_set_wins", rd, 32'h8);
    access(0, ADDR_SW, 32'h0, 4'hF, rd);
    check("sw_release", rd, sw_m);
    check("int_again", 32'(irq), 32'd1);

    sw = 16'h0030;
    idle(14);
    sw_m = 32'h30;

    b_we   = '{1'b1, 1'b0, 1'b0, 1'b0};
    b_addr = '{ADDR_LED, ADDR_LED, ADDR_SW, 3'd7};
    b_data = '{32'h00000BEE, 32'h0, 32'h0, 32'h0};
    b_exp  = '{32'h0, 32'h00000BEE, sw_m, 32'h0};
    drive(b_we[0], b_addr[0], b_data[0], 4'b0011);
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk);
      #1;
      check("burst_ack", 32'(bus.ack), 32'd1);
      check("burst_data", bus.dat_r, b_exp[i]);
      if (i < 3) drive(b_we[i+1], b_addr[i+1], b_data[i+1], 4'b0011);
      else bus.stb = 1'b0;
    end
    @(posedge i_clk);
    #1;
    check("burst_no_extra_ack", 32'(bus.ack), 32'd0);
    bus.cyc = 1'b0;
    led_m = 32'h0BEE;
    check("burst_leds", 32'(leds), led_m);

    // Reset in the ack cycle drops the ack.
    drive(1, ADDR_LED, 32'h0000FFFF, 4'b1111);
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    bus.stb = 1'b0;
    #1;
    check("rst_drop_ack", 32'(bus.ack), 32'd0);
    check("rst_stall_hi", 32'(bus.stall), 32'd1);
    @(posedge i_clk);
    #1;
    check("rst_leds_clr", 32'(leds), 32'd0);
    check("rst_int_clr", 32'(irq), 32'd0);
    idle(1);
    i_reset = 1'b0;
    bus.cyc = 1'b0;
    access(0, ADDR_IE, 32'h0, 4'hF, rd);
    check("rst_ie_clr", rd, 32'd0);
    access(1, ADDR_LED, 32'h00000005, 4'b0001, rd);
    check("post_rst_led", 32'(leds), 32'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
